// File: rtl/apb_slave_regfile.sv
// APB completer: 16x32 register file with read-only ID at index 0. Latency WAIT_CYCLES+1 sampled access cycles.
// pready is one registered pulse; DONE forces an idle cycle, and dropping psel mid-access aborts with no write.
module apb_slave_regfile #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        psel,
  input  logic        pen,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        wr_strobe,
  output logic [3:0]  wr_index
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        latch_req;
  logic        complete;
  req_t        req;
  logic [31:0] regs [16];

  logic [3:0]  idx;
  logic        err;
  logic        wr_commit;
  logic [31:0] rd_val;

  // Decode works only on the request captured in IDLE, so bus changes during ACCESS are ignored.
  assign idx       = req.addr[5:2];
  assign err       = (req.addr[1:0] != 2'b00) || (req.addr[31:6] != 26'd0) ||
                     (req.write && (idx == 4'd0));
  assign wr_commit = complete && req.write && !err;
  assign rd_val    = (idx == 4'd0) ? ID_VALUE : regs[idx];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch_req = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (psel) begin
          state_nxt = ACCESS;
          cnt_nxt   = 4'd0;
          latch_req = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (pen) begin
          if (cnt == WAIT_LIM) begin
            state_nxt = DONE;
            complete  = 1'b1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req       <= '0;
      prdata    <= 32'd0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= 4'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pready    <= complete;
      pslverr   <= complete && err;
      wr_strobe <= wr_commit;
      if (latch_req) begin
        req.write <= pwrite;
        req.addr  <= paddr;
        req.wdata <= pwdata;
      end
      if (wr_commit) begin
        regs[idx] <= req.wdata;
        wr_index  <= idx;
      end
      // prdata only moves on read completion so the master can sample it late.
      if (complete && !req.write) prdata <= err ? 32'd0 : rd_val;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: random and directed APB transfers against an array-based reference model.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA5B0_0001;
  localparam int W = 2;

  logic        pclk = 1'b0;
  logic        prst, psel, pen, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata, prdata0, prdata5;
  logic        pready, pready0, pready5;
  logic        pslverr, pslverr0, pslverr5;
  logic        wr_strobe, wr_strobe0, wr_strobe5;
  logic [3:0]  wr_index, wr_index0, wr_index5;

  int total = 0;
  int bad = 0;

  logic [31:0] mregs [16];
  logic [31:0] mprdata;

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.WAIT_CYCLES(2)) dut (
    .pclk(pclk), .prst(prst), .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .wr_strobe(wr_strobe), .wr_index(wr_index));

  apb_slave_regfile #(.WAIT_CYCLES(0)) dut_w0 (
    .pclk(pclk), .prst(prst), .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .wr_strobe(wr_strobe0), .wr_index(wr_index0));

  apb_slave_regfile #(.WAIT_CYCLES(5)) dut_w5 (
    .pclk(pclk), .prst(prst), .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata5), .pready(pready5), .pslverr(pslverr5),
    .wr_strobe(wr_strobe5), .wr_index(wr_index5));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  function automatic logic m_err(input logic wr, input logic [31:0] a);
    return (a % 4 != 0) || (a >= 64) || (wr && a < 4);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
    mprdata = 32'd0;
  endtask

  // Reference behaviour of one completed transfer; returns expected prdata/pslverr/strobe count.
  task automatic model_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] erd, output logic eerr, output int estb);
    eerr = m_err(wr, a);
    estb = (wr && !eerr) ? 1 : 0;
    if (!wr) mprdata = eerr ? 32'd0 : ((a < 4) ? ID : mregs[a[5:2]]);
    else if (!eerr) mregs[a[5:2]] = d;
    erd = mprdata;
  endtask

  // Drives one full transfer; bus values are scrambled after the setup edge.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output logic er, output int lat, output int strobes,
                      output logic [3:0] widx, output logic rdy_after);
    strobes = 0; lat = -1; rd = '0; er = 1'b0; widx = '0; rdy_after = 1'b1;
    @(negedge pclk);
    psel = 1'b1; pen = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk);
    for (int i = 0; i < hold; i++) begin
      @(negedge pclk);
      paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom);
      @(posedge pclk);
    end
    @(negedge pclk);
    pen = 1'b1; paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      if (wr_strobe) strobes++;
      if (pready) begin
        lat = i; rd = prdata; er = pslverr; widx = wr_index;
        break;
      end
    end
    psel = 1'b0; pen = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    rdy_after = pready;
    if (wr_strobe) strobes++;
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd; logic er, eerr, ra; int lat, stb, estb; logic [3:0] wi;
    prst = 1'b1; psel = 1'b0; pen = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    total++;
    if ({prdata, pready, pslverr, wr_strobe, wr_index} !== 39'd0) begin
      bad++; $display("FAIL reset_outputs: got prdata=%h rdy=%b err=%b stb=%b idx=%h want all 0",
                      prdata, pready, pslverr, wr_strobe, wr_index);
    end
    prst = 1'b0;
    m_reset();
    model_xfer(1'b0, 32'h00, 32'd0, erd, eerr, estb);
    xfer(1'b0, 32'h00, 32'd0, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (rd !== ID || er !== 1'b0) begin
      bad++; $display("FAIL reset_id_read: got %h err=%b want %h err=0", rd, er, ID);
    end
    total++;
    if (lat !== W + 1) begin
      bad++; $display("FAIL reset_id_latency: got %0d want %0d", lat, W + 1);
    end
    model_xfer(1'b0, 32'h3C, 32'd0, erd, eerr, estb);
    xfer(1'b0, 32'h3C, 32'd0, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      bad++; $display("FAIL reset_reg15_read: got %h err=%b want 0 err=0", rd, er);
    end
  endtask

  task automatic test_write_readback();
    logic [31:0] rd, erd; logic er, eerr, ra; int lat, stb, estb; logic [3:0] wi;
    model_xfer(1'b1, 32'h08, 32'hDEAD_BEEF, erd, eerr, estb);
    xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (stb !== 1 || wi !== 4'd2 || er !== 1'b0) begin
      bad++; $display("FAIL wr_strobe: got strobes=%0d idx=%0d err=%b want 1 idx=2 err=0", stb, wi, er);
    end
    total++;
    if (lat !== W + 1 || ra !== 1'b0) begin
      bad++; $display("FAIL wr_latency: got lat=%0d pready_after=%b want %0d and 0", lat, ra, W + 1);
    end
    total++;
    if (rd !== erd) begin
      bad++; $display("FAIL wr_keeps_prdata: got %h want %h", rd, erd);
    end
    model_xfer(1'b0, 32'h08, 32'd0, erd, eerr, estb);
    xfer(1'b0, 32'h08, 32'd0, 1, rd, er, lat, stb, wi, ra);
    total++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      bad++; $display("FAIL readback: got %h err=%b want deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eerr, ra; int lat, stb, estb; logic [3:0] wi;
    model_xfer(1'b1, 32'h00, 32'h1234, erd, eerr, estb);
    xfer(1'b1, 32'h00, 32'h1234, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (er !== 1'b1 || stb !== 0 || lat !== W + 1 || ra !== 1'b0) begin
      bad++; $display("FAIL err_id_write: got err=%b strobes=%0d lat=%0d after=%b want 1 0 %0d 0",
                      er, stb, lat, ra, W + 1);
    end
    model_xfer(1'b0, 32'h00, 32'd0, erd, eerr, estb);
    xfer(1'b0, 32'h00, 32'd0, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (rd !== ID || er !== 1'b0) begin
      bad++; $display("FAIL err_id_intact: got %h err=%b want %h err=0", rd, er, ID);
    end
    model_xfer(1'b0, 32'h40, 32'd0, erd, eerr, estb);
    xfer(1'b0, 32'h40, 32'd0, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (rd !== 32'd0 || er !== 1'b1 || ra !== 1'b0) begin
      bad++; $display("FAIL err_read_0x40: got %h err=%b after=%b want 0 err=1 after=0", rd, er, ra);
    end
    model_xfer(1'b1, 32'h06, 32'h5555_AAAA, erd, eerr, estb);
    xfer(1'b1, 32'h06, 32'h5555_AAAA, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (er !== 1'b1 || stb !== 0) begin
      bad++; $display("FAIL err_unaligned_write: got err=%b strobes=%0d want 1 0", er, stb);
    end
    model_xfer(1'b0, 32'h04, 32'd0, erd, eerr, estb);
    xfer(1'b0, 32'h04, 32'd0, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (rd !== erd) begin
      bad++; $display("FAIL err_unaligned_nowrite: got %h want %h", rd, erd);
    end
  endtask

  task automatic test_wait_sweep();
    logic h0 [12]; logic h2 [12]; logic h5 [12];
    int f0, f2, f5;
    logic [31:0] erd; logic eerr; int estb;
    for (int i = 0; i < 12; i++) begin h0[i] = 0; h2[i] = 0; h5[i] = 0; end
    @(negedge pclk);
    psel = 1'b1; pen = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'd0;
    @(posedge pclk);
    @(negedge pclk);
    pen = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      h0[i] = pready0; h2[i] = pready; h5[i] = pready5;
    end
    psel = 1'b0; pen = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    model_xfer(1'b0, 32'h0, 32'd0, erd, eerr, estb);
    f0 = 0; f2 = 0; f5 = 0;
    for (int i = 10; i >= 1; i--) begin
      if (h0[i]) f0 = i;
      if (h2[i]) f2 = i;
      if (h5[i]) f5 = i;
    end
    total++;
    if (f0 !== 1 || h0[f0 + 1] !== 1'b0) begin
      bad++; $display("FAIL sweep_w0: got first=%0d next=%b want 1 and 0", f0, h0[f0 + 1]);
    end
    total++;
    if (f2 !== 3 || h2[f2 + 1] !== 1'b0) begin
      bad++; $display("FAIL sweep_w2: got first=%0d next=%b want 3 and 0", f2, h2[f2 + 1]);
    end
    total++;
    if (f5 !== 6 || h5[f5 + 1] !== 1'b0) begin
      bad++; $display("FAIL sweep_w5: got first=%0d next=%b want 6 and 0", f5, h5[f5 + 1]);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, erd; logic er, eerr, ra; int lat, stb, estb; logic [3:0] wi;
    logic seen;
    model_xfer(1'b1, 32'h10, 32'h1111_2222, erd, eerr, estb);
    xfer(1'b1, 32'h10, 32'h1111_2222, 0, rd, er, lat, stb, wi, ra);
    @(negedge pclk);
    psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFE_0000;
    @(posedge pclk);
    @(negedge pclk);
    pen = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    seen = pready | wr_strobe;
    psel = 1'b0; pen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      seen = seen | pready | wr_strobe;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL abort_no_ready: got pready/strobe=%b want 0", seen);
    end
    model_xfer(1'b0, 32'h10, 32'd0, erd, eerr, estb);
    xfer(1'b0, 32'h10, 32'd0, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (rd !== 32'h1111_2222 || lat !== W + 1) begin
      bad++; $display("FAIL abort_old_value: got %h lat=%0d want 11112222 lat=%0d", rd, lat, W + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eerr, ra; int lat, stb, estb; logic [3:0] wi;
    model_xfer(1'b1, 32'h0C, 32'h0000_0077, erd, eerr, estb);
    xfer(1'b1, 32'h0C, 32'h0000_0077, 0, rd, er, lat, stb, wi, ra);
    @(negedge pclk);
    psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h0000_0099;
    @(posedge pclk);
    @(negedge pclk);
    pen = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    prst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    total++;
    if (pready !== 1'b0 || wr_strobe !== 1'b0 || prdata !== 32'd0) begin
      bad++; $display("FAIL rst_mid_outputs: got rdy=%b stb=%b prdata=%h want 0 0 0",
                      pready, wr_strobe, prdata);
    end
    prst = 1'b0; psel = 1'b0; pen = 1'b0;
    m_reset();
    model_xfer(1'b0, 32'h0C, 32'd0, erd, eerr, estb);
    xfer(1'b0, 32'h0C, 32'd0, 0, rd, er, lat, stb, wi, ra);
    total++;
    if (rd !== erd || lat !== W + 1) begin
      bad++; $display("FAIL rst_mid_read: got %h lat=%0d want %h lat=%0d", rd, lat, erd, W + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic er, eerr, ra, wr; int lat, stb, estb, sel; logic [3:0] wi;
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom);
      sel = int'($urandom % 8);
      if (sel < 5)       a = ($urandom % 16) * 4;
      else if (sel == 5) a = ($urandom % 16) * 4 + 1 + ($urandom % 3);
      else if (sel == 6) a = 32'h40 + ($urandom % 64) * 4;
      else               a = $urandom;
      d = $urandom;
      model_xfer(wr, a, d, erd, eerr, estb);
      xfer(wr, a, d, int'($urandom % 3), rd, er, lat, stb, wi, ra);
      total++;
      if (rd !== erd || er !== eerr) begin
        bad++; $display("FAIL rand_data[%0d] addr=%h wr=%b: got %h err=%b want %h err=%b",
                        n, a, wr, rd, er, erd, eerr);
      end
      total++;
      if (stb !== estb || lat !== W + 1 || ra !== 1'b0) begin
        bad++; $display("FAIL rand_ctrl[%0d] addr=%h: got strobes=%0d lat=%0d after=%b want %0d %0d 0",
                        n, a, stb, lat, ra, estb, W + 1);
      end
      if (estb == 1) begin
        total++;
        if (wi !== a[5:2]) begin
          bad++; $display("FAIL rand_wr_index[%0d]: got %0d want %0d", n, wi, a[5:2]);
        end
      end
    end
  endtask

  initial begin
    prst = 1'b1; psel = 1'b0; pen = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    m_reset();
    test_reset();
    test_write_readback();
    test_errors();
    test_wait_sweep();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
